vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Successor to the fixed 640x480@60 display controller.
- Derives a pixel-rate enable from the system clock and runs horizontal and vertical counters.
- Produces sync, blanking, active-area coordinates and frame/line strobes for the downstream pixel renderers (board/checker drawing).
- Any mode with the ordering sync -> back porch -> active -> front porch is supported through parameters.

Parameters:
- CLK_DIV, 4, system clocks per pixel; must be >= 1. 1 = tick every cycle.
- CNT_W, 10, width of the raw counters and coordinate outputs.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- H_ACTIVE, 640, horizontal visible pixels.
- H_FP, 16, horizontal front porch in pixels.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- V_ACTIVE, 480, vertical visible lines.
- V_FP, 10, vertical front porch in lines.
- SYNC_POL, 1, asserted level of hSync and vSync (1 = active-high, matching the existing board wiring).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- pix_en  out  1  one-clk pulse every CLK_DIV clocks; counters and outputs update only on this pulse.
- hCount  out  CNT_W  raw horizontal position, 0..H_TOTAL-1.
- vCount  out  CNT_W  raw vertical position, 0..V_TOTAL-1.
- hSync  out  1  horizontal sync, level set by SYNC_POL.
- vSync  out  1  vertical sync, level set by SYNC_POL.
- bright  out  1  high while in the active area.
- pixel_x  out  CNT_W  active-relative column; 0 when not bright.
- pixel_y  out  CNT_W  active-relative row; 0 when not bright.
- line_start  out  1  one-clk pulse, coincident with pix_en, when hCount becomes 0.
- frame_start  out  1  one-clk pulse, coincident with pix_en, when hCount and vCount both become 0.

Behaviour:
- Derived constants: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; H_ACT0 = H_SYNC+H_BP; V_ACT0 = V_SYNC+V_BP.
- Divider: counter div runs 0..CLK_DIV-1 and wraps. pix_en is registered high on the clock after div = CLK_DIV-1. With CLK_DIV = 1, pix_en is held high continuously after reset.
- On each cycle where pix_en is high:
  - If hCount < H_TOTAL-1, hCount increments.
  - Otherwise hCount goes to 0 and vCount increments; if vCount = V_TOTAL-1, vCount goes to 0 instead.
- All other outputs are registered and decoded from the next counter values, so they are aligned in the same cycle as hCount/vCount. There is no pipeline skew between coordinates, sync and bright.
- hSync = SYNC_POL when hCount < H_SYNC, else the inverse level.
- vSync = SYNC_POL when vCount < V_SYNC, else the inverse level.
- bright = 1 when H_ACT0 <= hCount < H_ACT0+H_ACTIVE and V_ACT0 <= vCount < V_ACT0+V_ACTIVE. Ranges are inclusive-exclusive; the legacy off-by-one at line 515 is fixed.
- pixel_x = hCount-H_ACT0 and pixel_y = vCount-V_ACT0 when bright; both 0 otherwise.
- line_start and frame_start are high only for the single clock in which pix_en is high and the new counter value meets their condition.
- Reset values, on the clock with reset high: div = 0, pix_en = 0, hCount = 0, vCount = 0, bright = 0, pixel_x = 0, pixel_y = 0, line_start = 0, frame_start = 0, hSync = ~SYNC_POL, vSync = ~SYNC_POL.
- Sync outputs are deasserted during reset, then asserted from the first pix_en onward.
- First pix_en after reset release:
  - Occurs CLK_DIV clocks after release.
  - hCount goes to 1.
  - Position (0,0) is not re-announced; the first frame_start comes at the first full wrap.
- Reset mid-frame: takes effect on the next clock regardless of div phase, with no partial strobe.
- Reset has priority over pix_en.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. Requirement: CNT_W must hold H_TOTAL-1 and V_TOTAL-1; the implementation flags a violation with an elaboration-time $error.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- When defined:
  - Adds output frame_count [15:0].
  - Reset value is 0.
  - Increments by 1, wrapping 16'hFFFF -> 0, on the same clock that frame_start pulses.
  - Used by renderers for blink/animation.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Defaults, CLK_DIV=4, reset released: first pix_en on clock 4 after release with hCount=1. Over 100 frames, pix_en spacing is exactly 4 clocks; hCount wraps 799->0; vCount wraps 524->0.
- Defaults: hSync=1 exactly for hCount 0..95. vSync=1 exactly for vCount 0..1. bright=1 exactly for hCount 144..783 and vCount 35..514, giving 307200 bright pix_en cycles per frame.
- Defaults: at hCount=144, vCount=35, pixel_x=0 and pixel_y=0. At hCount=783, vCount=514, pixel_x=639 and pixel_y=479. Both read 0 at hCount=784.
- CLK_DIV=1, SYNC_POL=0, small mode (H 4/2/8/2, V 1/1/4/1): hSync is low for hCount 0..3 and high elsewhere. frame_start pulses every 16*7=112 clocks. line_start pulses every 16 clocks.
- Assert reset for 1 clock at hCount=400, vCount=300, mid-div phase: next clock all counters are 0, sync outputs are inactive, and there is no frame_start. Timing then restarts as after power-up.
- With VGA_FRAME_CNT_EN defined, run 3 frames: frame_count reads 0, 1, 2, 3, incrementing in the same clock as each frame_start. Preloading via force to 16'hFFFF wraps to 0 at the next frame_start.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// A clock divider produces a pixel-rate enable; horizontal and vertical
// counters advance on that enable, and sync, blanking, active-area
// coordinates and line/frame strobes are registered from the next counter
// values so every output lines up in the same cycle as hCount/vCount.
// Optional feature: define VGA_FRAME_CNT_EN to add a 16-bit frame counter
// output (frame_count) that steps on every frame_start.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int CNT_W    = 10,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             pix_en,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             hSync,
    output logic             vSync,
    output logic             bright,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_ACT0  = H_SYNC + H_BP;
    localparam int V_ACT0  = V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_FIRST = CNT_W'(H_ACT0);
    localparam logic [CNT_W-1:0] H_ACT_LAST  = CNT_W'(H_ACT0 + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_FIRST = CNT_W'(V_ACT0);
    localparam logic [CNT_W-1:0] V_ACT_LAST  = CNT_W'(V_ACT0 + V_ACTIVE - 1);

    // Parameter sanity: a bad mode must fail at elaboration, not misbehave.
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if ((H_TOTAL - 1) >= (2 ** CNT_W) || (V_TOTAL - 1) >= (2 ** CNT_W)) begin : g_bad_width
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
    end

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             bright_next;
    logic             frame_next;

    // The clock that wraps the divider is the clock on which pix_en is set.
    assign tick = (div == DIV_LAST);

    // Pixel-rate divider; pix_en is a registered copy of the wrap condition.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else begin
            pix_en <= tick;
            div    <= tick ? '0 : div + DIV_W'(1);
        end
    end

    // Next raster position, plus the decodes that depend on it.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        h_next = hCount + CNT_W'(1);
        v_next = vCount;
        if (hCount == H_LAST) begin
            h_next = '0;
            v_next = (vCount == V_LAST) ? '0 : vCount + CNT_W'(1);
        end
        bright_next = (h_next >= H_ACT_FIRST) && (h_next <= H_ACT_LAST) &&
                      (v_next >= V_ACT_FIRST) && (v_next <= V_ACT_LAST);
        frame_next  = tick && (h_next == '0) && (v_next == '0);
    end

    // Counters and decoded outputs, all updated together on the pixel enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            hCount      <= '0;
            vCount      <= '0;
            hSync       <= ~SYNC_POL;
            vSync       <= ~SYNC_POL;
            bright      <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (tick) begin
                hCount      <= h_next;
                vCount      <= v_next;
                hSync       <= (h_next < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
                vSync       <= (v_next < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
                bright      <= bright_next;
                pixel_x     <= bright_next ? h_next - H_ACT_FIRST : '0;
                pixel_y     <= bright_next ? v_next - V_ACT_FIRST : '0;
                line_start  <= (h_next == '0);
                frame_start <= frame_next;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frame counter for blink/animation; steps on the same clock as frame_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= 16'd0;
        end else begin
            frame_count <= frame_count + 16'(frame_next);
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen. Four instances cover
// the default mode, a tiny CLK_DIV=1 active-low mode, the default horizontal
// window and the default vertical window. A small raster model in the bench
// supplies every expected value.
module tb_vga_timing_gen;

    localparam int W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    logic rst_d = 1'b1;

    int checks = 0;
    int errors = 0;

    logic         pe [4];
    logic [W-1:0] hc [4];
    logic [W-1:0] vc [4];
    logic         hs [4];
    logic         vs [4];
    logic         br [4];
    logic [W-1:0] px [4];
    logic [W-1:0] py [4];
    logic         ls [4];
    logic         fs [4];
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]  fc [4];
`endif

    // Geometry of each instance: 0 default, 1 small, 2 H-window, 3 V-window.
    int g_hs  [4] = '{96, 4, 96, 1};
    int g_hb  [4] = '{48, 2, 48, 1};
    int g_ha  [4] = '{640, 8, 640, 2};
    int g_hf  [4] = '{16, 2, 16, 1};
    int g_vs  [4] = '{2, 1, 2, 2};
    int g_vb  [4] = '{33, 1, 1, 33};
    int g_va  [4] = '{480, 4, 2, 480};
    int g_vf  [4] = '{10, 1, 1, 10};
    int g_div [4] = '{4, 1, 1, 1};
    bit g_pol [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Model state: clocks since reset release, raster position, frame count.
    int          m_clk [4];
    int          m_h   [4];
    int          m_v   [4];
    logic [15:0] m_fc  [4];

    vga_timing_gen u_a (
        .clk(clk), .reset(rst_a), .pix_en(pe[0]), .hCount(hc[0]), .vCount(vc[0]),
        .hSync(hs[0]), .vSync(vs[0]), .bright(br[0]), .pixel_x(px[0]), .pixel_y(py[0]),
        .line_start(ls[0]), .frame_start(fs[0])
`ifdef VGA_FRAME_CNT_EN
        , .frame_count(fc[0])
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1), .SYNC_POL(1'b0),
        .H_SYNC(4), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1)
    ) u_b (
        .clk(clk), .reset(rst_b), .pix_en(pe[1]), .hCount(hc[1]), .vCount(vc[1]),
        .hSync(hs[1]), .vSync(vs[1]), .bright(br[1]), .pixel_x(px[1]), .pixel_y(py[1]),
        .line_start(ls[1]), .frame_start(fs[1])
`ifdef VGA_FRAME_CNT_EN
        , .frame_count(fc[1])
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1), .V_SYNC(2), .V_BP(1), .V_ACTIVE(2), .V_FP(1)
    ) u_c (
        .clk(clk), .reset(rst_c), .pix_en(pe[2]), .hCount(hc[2]), .vCount(vc[2]),
        .hSync(hs[2]), .vSync(vs[2]), .bright(br[2]), .pixel_x(px[2]), .pixel_y(py[2]),
        .line_start(ls[2]), .frame_start(fs[2])
`ifdef VGA_FRAME_CNT_EN
        , .frame_count(fc[2])
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_SYNC(1), .H_BP(1), .H_ACTIVE(2), .H_FP(1)
    ) u_d (
        .clk(clk), .reset(rst_d), .pix_en(pe[3]), .hCount(hc[3]), .vCount(vc[3]),
        .hSync(hs[3]), .vSync(vs[3]), .bright(br[3]), .pixel_x(px[3]), .pixel_y(py[3]),
        .line_start(ls[3]), .frame_start(fs[3])
`ifdef VGA_FRAME_CNT_EN
        , .frame_count(fc[3])
`endif
    );

    task automatic chk(input int id, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL u%0d.%s at clk %0d: observed %0d expected %0d", id, tag, m_clk[id], obs, exp);
        end
    endtask

    task automatic model_reset(input int id);
        m_clk[id] = 0;
        m_h[id]   = 0;
        m_v[id]   = 0;
        m_fc[id]  = 16'd0;
    endtask

    task automatic check_reset(input int id);
        chk(id, "rst_pix_en", pe[id], 0);
        chk(id, "rst_hcount", hc[id], 0);
        chk(id, "rst_vcount", vc[id], 0);
        chk(id, "rst_hsync", hs[id], !g_pol[id]);
        chk(id, "rst_vsync", vs[id], !g_pol[id]);
        chk(id, "rst_bright", br[id], 0);
        chk(id, "rst_pixel_x", px[id], 0);
        chk(id, "rst_pixel_y", py[id], 0);
        chk(id, "rst_line_start", ls[id], 0);
        chk(id, "rst_frame_start", fs[id], 0);
`ifdef VGA_FRAME_CNT_EN
        chk(id, "rst_frame_count", fc[id], 0);
`endif
    endtask

    // Advance instance id by n clocks, checking every output after each edge.
    task automatic run(input int id, input int n);
        int   htot, vtot, ha0, va0;
        bit   tick, ls_e, fs_e, br_e, started;
        logic ex_hs, ex_vs;
        htot = g_hs[id] + g_hb[id] + g_ha[id] + g_hf[id];
        vtot = g_vs[id] + g_vb[id] + g_va[id] + g_vf[id];
        ha0  = g_hs[id] + g_hb[id];
        va0  = g_vs[id] + g_vb[id];
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            m_clk[id]++;
            tick = (m_clk[id] % g_div[id]) == 0;
            ls_e = 1'b0;
            fs_e = 1'b0;
            if (tick) begin
                if (m_h[id] == htot - 1) begin
                    m_h[id] = 0;
                    m_v[id] = (m_v[id] == vtot - 1) ? 0 : m_v[id] + 1;
                    ls_e    = 1'b1;
                    fs_e    = (m_v[id] == 0);
                end else begin
                    m_h[id]++;
                end
            end
            if (fs_e) m_fc[id] = m_fc[id] + 16'd1;
            started = m_clk[id] >= g_div[id];
            ex_hs = started ? ((m_h[id] < g_hs[id]) == g_pol[id]) : !g_pol[id];
            ex_vs = started ? ((m_v[id] < g_vs[id]) == g_pol[id]) : !g_pol[id];
            br_e  = (m_h[id] >= ha0) && (m_h[id] < ha0 + g_ha[id]) &&
                    (m_v[id] >= va0) && (m_v[id] < va0 + g_va[id]);
            chk(id, "pix_en", pe[id], tick);
            chk(id, "hcount", hc[id], m_h[id]);
            chk(id, "vcount", vc[id], m_v[id]);
            chk(id, "hsync", hs[id], ex_hs);
            chk(id, "vsync", vs[id], ex_vs);
            chk(id, "bright", br[id], br_e);
            chk(id, "pixel_x", px[id], br_e ? m_h[id] - ha0 : 0);
            chk(id, "pixel_y", py[id], br_e ? m_v[id] - va0 : 0);
            chk(id, "line_start", ls[id], ls_e);
            chk(id, "frame_start", fs[id], fs_e);
`ifdef VGA_FRAME_CNT_EN
            chk(id, "frame_count", fc[id], m_fc[id]);
`endif
        end
    endtask

    initial begin
        // Power-up: all instances held in reset.
        repeat (3) @(negedge clk);
        for (int id = 0; id < 4; id++) check_reset(id);

        // Default mode: first pix_en four clocks after release, hCount = 1.
        rst_a = 1'b0;
        model_reset(0);
        run(0, 4);
        chk(0, "first_pix_en", pe[0], 1);
        chk(0, "first_hcount", hc[0], 1);
        // Two full lines and half of a third: pix_en spacing, 799->0 wrap, hsync edges.
        run(0, 7998);
        chk(0, "pre_reset_hcount", hc[0], 400);
        chk(0, "pre_reset_vcount", vc[0], 2);

        // One-clock reset mid-line, two clocks into the divider phase.
        rst_a = 1'b1;
        @(negedge clk);
        check_reset(0);
        rst_a = 1'b0;
        model_reset(0);
        run(0, 8);
        chk(0, "restart_hcount", hc[0], 2);

        // Small active-low mode: line every 16 clocks, frame every 112.
        rst_b = 1'b0;
        model_reset(1);
        run(1, 112);
        chk(1, "first_frame_start", fs[1], 1);
        chk(1, "first_frame_hcount", hc[1], 0);
        run(1, 117);
`ifdef VGA_FRAME_CNT_EN
        chk(1, "frame_count_two", fc[1], 2);
        force u_b.frame_count = 16'hFFFF;
        m_fc[1] = 16'hFFFF;
        run(1, 1);
        release u_b.frame_count;
        run(1, 112);
        chk(1, "frame_count_wrap", fc[1], 0);
`endif

        // Default horizontal window (144..783) over one short frame.
        rst_c = 1'b0;
        model_reset(2);
        run(2, 4810);

        // Default vertical window (35..514), vsync 0..1, 524->0 wrap.
        rst_d = 1'b0;
        model_reset(3);
        run(3, 2635);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
